// File: rtl/div_pipe_rv.sv
// div_pipe_rv: fully pipelined RV32M/RV64M divider (DIV/DIVU/REM/REMU), non-restoring,
// BITS_PER_STAGE quotient bits per stage, valid/ready with global stall and flush.
`default_nettype none

module div_pipe_rv #(
  parameter int DATA_WIDTH     = 32,
  parameter int BITS_PER_STAGE = 2,
  parameter int TAG_WIDTH      = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [1:0]            in_op,
  input  logic [DATA_WIDTH-1:0] in_dividend,
  input  logic [DATA_WIDTH-1:0] in_divisor,
  input  logic [TAG_WIDTH-1:0]  in_tag,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_result,
  output logic [TAG_WIDTH-1:0]  out_tag
);

  localparam int STAGES = DATA_WIDTH / BITS_PER_STAGE;
  localparam logic [DATA_WIDTH-1:0] MIN_VAL = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  // Index 0 is the capture register; 1..STAGES are the iteration stages.
  logic [DATA_WIDTH:0]   st_a   [0:STAGES];
  logic [DATA_WIDTH-1:0] st_q   [0:STAGES];
  logic [DATA_WIDTH:0]   st_m   [0:STAGES];
  logic [DATA_WIDTH-1:0] st_dvd [0:STAGES];
  logic [TAG_WIDTH-1:0]  st_tag [0:STAGES];
  logic [STAGES:0]       st_valid, st_rem, st_qneg, st_rneg, st_dz, st_ovf;

  logic [DATA_WIDTH:0]   nxt_a  [1:STAGES];
  logic [DATA_WIDTH-1:0] nxt_q  [1:STAGES];

  logic                  stall;
  logic                  is_signed, sign_a, sign_b, cap_dz, cap_ovf;
  logic [DATA_WIDTH-1:0] abs_a, abs_b;
  logic [DATA_WIDTH:0]   a_t;
  logic [DATA_WIDTH-1:0] q_t;
  logic                  sub;
  logic [DATA_WIDTH-1:0] rem_raw, q_fix, r_fix, res_next;

  assign stall    = out_valid & ~out_ready;
  assign in_ready = ~rst & ~flush & ~stall;

  assign is_signed = ~in_op[0];
  assign sign_a    = is_signed & in_dividend[DATA_WIDTH-1];
  assign sign_b    = is_signed & in_divisor[DATA_WIDTH-1];
  assign abs_a     = sign_a ? (~in_dividend + 1'b1) : in_dividend;
  assign abs_b     = sign_b ? (~in_divisor + 1'b1) : in_divisor;
  assign cap_dz    = (in_divisor == '0);
  assign cap_ovf   = is_signed & (in_dividend == MIN_VAL) & (&in_divisor);

  // Non-restoring step: the add/subtract choice uses the sign of A before the shift.
  always_comb begin
    a_t = '0;
    q_t = '0;
    sub = 1'b0;
    for (int s = 1; s <= STAGES; s++) begin
      a_t = st_a[s-1];
      q_t = st_q[s-1];
      for (int b = 0; b < BITS_PER_STAGE; b++) begin
        sub        = ~a_t[DATA_WIDTH];
        {a_t, q_t} = {a_t[DATA_WIDTH-1:0], q_t, 1'b0};
        a_t        = sub ? (a_t - st_m[s-1]) : (a_t + st_m[s-1]);
        q_t[0]     = ~a_t[DATA_WIDTH];
      end
      nxt_a[s] = a_t;
      nxt_q[s] = q_t;
    end
  end

  always_comb begin
    rem_raw = st_a[STAGES][DATA_WIDTH] ?
              (st_a[STAGES][DATA_WIDTH-1:0] + st_m[STAGES][DATA_WIDTH-1:0]) :
              st_a[STAGES][DATA_WIDTH-1:0];
    q_fix   = st_qneg[STAGES] ? (~st_q[STAGES] + 1'b1) : st_q[STAGES];
    r_fix   = st_rneg[STAGES] ? (~rem_raw + 1'b1) : rem_raw;
    if (st_dz[STAGES]) begin
      q_fix = '1;
      r_fix = st_dvd[STAGES];
    end else if (st_ovf[STAGES]) begin
      q_fix = MIN_VAL;
      r_fix = '0;
    end
    res_next = st_rem[STAGES] ? r_fix : q_fix;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st_valid   <= '0;
      out_valid  <= 1'b0;
      out_result <= '0;
      out_tag    <= '0;
      for (int s = 0; s <= STAGES; s++) begin
        st_a[s] <= '0;
        st_q[s] <= '0;
        st_m[s] <= '0;
      end
    end else if (flush) begin
      st_valid  <= '0;
      out_valid <= 1'b0;
    end else if (!stall) begin
      st_valid  <= {st_valid[STAGES-1:0], in_valid};
      st_rem    <= {st_rem[STAGES-1:0], in_op[1]};
      st_qneg   <= {st_qneg[STAGES-1:0], sign_a ^ sign_b};
      st_rneg   <= {st_rneg[STAGES-1:0], sign_a};
      st_dz     <= {st_dz[STAGES-1:0], cap_dz};
      st_ovf    <= {st_ovf[STAGES-1:0], cap_ovf};
      st_a[0]   <= '0;
      st_q[0]   <= abs_a;
      st_m[0]   <= {1'b0, abs_b};
      st_dvd[0] <= in_dividend;
      st_tag[0] <= in_tag;
      for (int s = 1; s <= STAGES; s++) begin
        st_a[s]   <= nxt_a[s];
        st_q[s]   <= nxt_q[s];
        st_m[s]   <= st_m[s-1];
        st_dvd[s] <= st_dvd[s-1];
        st_tag[s] <= st_tag[s-1];
      end
      out_valid  <= st_valid[STAGES];
      out_result <= res_next;
      out_tag    <= st_tag[STAGES];
    end
  end

endmodule

`default_nettype wire
